// File: rtl/ddr_writer.sv
// ddr_writer: write-back DMA front end for the conv array.
// Drains each conv unit's output buffer in chunks of up to UNIT_BURSTS bursts,
// streams the words to the DDR write master's AXI-Stream slave and programs
// that master through WSTART_REG / WADDR_REG / WNBURST_REG, waiting on WDONE_REG.
// Chunks are issued round-robin over the active conv units.
// Optional build macro DDR_WRITER_STATS_EN adds the stat_beats / stat_stall
// counters; without it those ports and counters do not exist.
//
// state | meaning
// IDLE  | ready for a configuration word
// SEL   | waiting for the current conv unit's buffer to hold its chunk
// START | chunk size latched, write master kicked
// XFER  | popping the buffer and streaming beats to the write master
// WAIT  | all beats accepted, waiting for the write master to finish
// INCR  | advance address, remaining bursts and conv unit
// FIN   | one-cycle done pulse

module ddr_writer #(
  parameter int N_CONV_UNIT  = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 15,
  parameter int UNIT_BURSTS  = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              cfg_i_valid,
  output logic                              cfg_i_ready,
  input  logic [63:0]                       cfg_i_data,
  input  logic [N_CONV_UNIT-1:0]            ob_suff,
  output logic [N_CONV_UNIT-1:0]            ob_rd_en,
  input  logic [N_CONV_UNIT*DATA_WIDTH-1:0] ob_dout,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              WSTART_REG,
  output logic [31:0]                       WADDR_REG,
  output logic [31:0]                       WNBURST_REG,
  input  logic                              WDONE_REG,
  output logic                              done_o,
  output logic                              busy_o
`ifdef DDR_WRITER_STATS_EN
  ,
  output logic [31:0]                       stat_beats,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int BEATS_PER_BURST = BURST_LENGTH + 1;
  localparam int BURST_BYTES     = BEATS_PER_BURST * DATA_WIDTH / 8;
  localparam int NB_W            = $clog2(UNIT_BURSTS) + 1;
  localparam int BEAT_W          = $clog2(UNIT_BURSTS * BEATS_PER_BURST) + 1;
  localparam int BB_W            = (BEATS_PER_BURST > 1) ? $clog2(BEATS_PER_BURST) : 1;
  localparam int CU_W            = (N_CONV_UNIT > 1) ? $clog2(N_CONV_UNIT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_INCR  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]            state;
  logic [31:0]           addr;
  logic [17:0]           rem;
  logic [CU_W-1:0]       n_cu_m1;
  logic [CU_W-1:0]       cu;

  logic [BEAT_W-1:0]     rd_cnt;
  logic [BEAT_W-1:0]     tx_cnt;
  logic [BB_W-1:0]       bcnt;

  logic                  inflight;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  skid_wr;
  logic                  skid_rd;
  logic [1:0]            skid_cnt;

  logic [NB_W-1:0]       nb_c;
  logic [BEAT_W-1:0]     beats_c;
  logic [3:0]            cfg_ncu;
  logic [CU_W-1:0]       cfg_ncu_m1;
  logic                  cfg_accept;
  logic [9:0]            cfg_unused;
  logic [DATA_WIDTH-1:0] ob_word;
  logic                  skid_empty;
  logic                  pop;
  logic                  rd_fire;
  logic [2:0]            occ;
  logic                  skid_push;
  logic                  skid_pop;

  assign cfg_unused = cfg_i_data[63:54];
  assign cfg_ncu    = cfg_i_data[53:50];
  assign cfg_accept = (state == S_IDLE) && cfg_i_valid;

  // Active CU count: 0 means one unit, anything above the unit count is clamped.
  always_comb begin
    cfg_ncu_m1 = '0;
    if (cfg_ncu == 4'd0) begin
      cfg_ncu_m1 = '0;
    end else if (int'(cfg_ncu) >= N_CONV_UNIT) begin
      cfg_ncu_m1 = CU_W'(N_CONV_UNIT - 1);
    end else begin
      cfg_ncu_m1 = CU_W'(cfg_ncu - 4'd1);
    end
  end

  // Chunk size is derived from the remaining bursts, which only change in INCR,
  // so it is valid from START through WAIT without a register.
  always_comb begin
    nb_c = NB_W'(UNIT_BURSTS);
    if (rem < 18'(UNIT_BURSTS)) begin
      nb_c = NB_W'(rem);
    end
    beats_c = BEAT_W'(nb_c) * BEAT_W'(BEATS_PER_BURST);
  end

  // Stream head: the skid FIFO when it holds data, otherwise the word returning
  // from the buffer this cycle, so the first beat goes out one cycle after the pop.
  assign ob_word       = ob_dout[cu*DATA_WIDTH +: DATA_WIDTH];
  assign skid_empty    = (skid_cnt == 2'd0);
  assign m_axis_tvalid = !skid_empty || inflight;
  assign m_axis_tdata  = skid_empty ? ob_word : skid_mem[skid_rd];
  assign m_axis_tlast  = (bcnt == BB_W'(BURST_LENGTH));
  assign pop           = m_axis_tvalid && m_axis_tready;

  // A read may be issued only if the returning word is guaranteed a skid slot.
  assign occ       = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_fire   = (state == S_XFER) && (rd_cnt < beats_c) && (occ < 3'd2);
  assign skid_push = inflight && !(skid_empty && pop);
  assign skid_pop  = pop && !skid_empty;

  // One-hot buffer pop on the selected conv unit only.
  always_comb begin
    ob_rd_en = '0;
    if (rd_fire) begin
      ob_rd_en[cu] = 1'b1;
    end
  end

  assign cfg_i_ready = rstn && (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_FIN);
  assign WSTART_REG  = (state == S_START) || (state == S_XFER) || (state == S_WAIT);
  assign WADDR_REG   = WSTART_REG ? addr : 32'd0;
  assign WNBURST_REG = WSTART_REG ? 32'(nb_c) : 32'd0;

  // Sequencing FSM and per-configuration address / burst / unit bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      addr    <= '0;
      rem     <= '0;
      n_cu_m1 <= '0;
      cu      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_i_valid) begin
            addr    <= cfg_i_data[31:0];
            rem     <= cfg_i_data[49:32];
            n_cu_m1 <= cfg_ncu_m1;
            cu      <= '0;
            state   <= (cfg_i_data[49:32] == 18'd0) ? S_FIN : S_SEL;
          end
        end
        S_SEL: begin
          if (ob_suff[cu]) begin
            state <= S_START;
          end
        end
        S_START: begin
          state <= S_XFER;
        end
        S_XFER: begin
          if (tx_cnt == beats_c) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (WDONE_REG) begin
            state <= S_INCR;
          end
        end
        S_INCR: begin
          addr  <= addr + 32'(nb_c) * 32'(BURST_BYTES);
          rem   <= rem - 18'(nb_c);
          cu    <= (cu == n_cu_m1) ? '0 : cu + CU_W'(1);
          state <= (rem == 18'(nb_c)) ? S_FIN : S_SEL;
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Chunk read / transmit counters and the beat position inside the current burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
      bcnt   <= '0;
    end else if (state == S_START) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
      bcnt   <= '0;
    end else begin
      if (rd_fire) begin
        rd_cnt <= rd_cnt + BEAT_W'(1);
      end
      if (pop) begin
        tx_cnt <= tx_cnt + BEAT_W'(1);
        bcnt   <= (bcnt == BB_W'(BURST_LENGTH)) ? '0 : bcnt + BB_W'(1);
      end
    end
  end

  // Two-entry skid FIFO absorbing words that return while the stream is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight    <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_wr     <= 1'b0;
      skid_rd     <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      inflight <= rd_fire;
      if (skid_push) begin
        skid_mem[skid_wr] <= ob_word;
        skid_wr           <= ~skid_wr;
      end
      if (skid_pop) begin
        skid_rd <= ~skid_rd;
      end
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

`ifdef DDR_WRITER_STATS_EN
  // Saturating accepted-beat and stall-cycle counters, cleared per configuration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else if (cfg_accept) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && (stat_beats != 32'hFFFF_FFFF)) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`else
  // Statistics disabled: accept strobe has no consumer in this build.
  logic cfg_accept_unused;
  assign cfg_accept_unused = cfg_accept;
`endif

endmodule

// File: tb/tb_ddr_writer.sv
// tb_ddr_writer: directed sequence of configurations with random buffer data and
// random back-pressure, checked against a chunk-level reference model.
module tb_ddr_writer;

  localparam int N  = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cfg_i_valid = 1'b0;
  logic          cfg_i_ready;
  logic [63:0]   cfg_i_data = '0;
  logic [N-1:0]  ob_suff = '1;
  logic [N-1:0]  ob_rd_en;
  logic [N*DW-1:0] ob_dout = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          WSTART_REG;
  logic [31:0]   WADDR_REG;
  logic [31:0]   WNBURST_REG;
  logic          WDONE_REG = 1'b0;
  logic          done_o;
  logic          busy_o;

  always #5 clk = ~clk;

  ddr_writer #(.N_CONV_UNIT(N), .DATA_WIDTH(DW), .BURST_LENGTH(15), .UNIT_BURSTS(8)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_i_valid(cfg_i_valid), .cfg_i_ready(cfg_i_ready), .cfg_i_data(cfg_i_data),
    .ob_suff(ob_suff), .ob_rd_en(ob_rd_en), .ob_dout(ob_dout),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .WSTART_REG(WSTART_REG), .WADDR_REG(WADDR_REG), .WNBURST_REG(WNBURST_REG),
    .WDONE_REG(WDONE_REG), .done_o(done_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] bufm [N][512];
  int          bptr [N];

  logic [63:0] got_q[$];
  logic        got_last[$];
  logic [31:0] ws_addr[$];
  logic [31:0] ws_nb[$];
  int          pops [N];

  logic [63:0] exp_data[$];
  logic        exp_last[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_nb[$];
  int          exp_pops [N];

  int done_cnt, oh_err, rd_wo_ws, stab_err, zero_err, chunk_rx, cyc;
  int first_ws, first_rd, first_v, first_beat, last_beat;
  logic        prev_stall = 1'b0;
  logic        prev_ws = 1'b0;
  logic        wst_s = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] wnb_s = '0;
  logic [N-1:0] rd_en_s = '0;
  int tready_mode = 0;
  int wdone_mode = 0;

  // Monitor: samples everything on the falling edge, between active edges.
  always @(negedge clk) begin
    cyc++;
    if (m_axis_tvalid && prev_stall && (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
      stab_err++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (m_axis_tvalid && first_v < 0) first_v = cyc;
    if (ob_rd_en != '0) begin
      if ($countones(ob_rd_en) > 1) oh_err++;
      if (!WSTART_REG) rd_wo_ws++;
      for (int i = 0; i < N; i++) if (ob_rd_en[i]) pops[i]++;
      if (first_rd < 0) first_rd = cyc;
    end
    rd_en_s = ob_rd_en;
    if (!WSTART_REG && (WADDR_REG !== 32'd0 || WNBURST_REG !== 32'd0)) zero_err++;
    if (WSTART_REG && !prev_ws) begin
      ws_addr.push_back(WADDR_REG);
      ws_nb.push_back(WNBURST_REG);
      chunk_rx = 0;
      if (first_ws < 0) first_ws = cyc;
    end
    prev_ws = WSTART_REG;
    wst_s   = WSTART_REG;
    wnb_s   = WNBURST_REG;
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
      chunk_rx++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (done_o) done_cnt++;
  end

  // Environment: output buffers, back-pressure and write-master completion.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_en_s[i]) begin
        ob_dout[i*DW +: DW] = bufm[i][bptr[i]];
        bptr[i]++;
      end
    end
    m_axis_tready = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    WDONE_REG = (wdone_mode == 1) ? 1'b1 : (wst_s && (chunk_rx == int'(wnb_s) * 16));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: chunk list and beat stream from the configuration rules.
  task automatic build_expect(input logic [31:0] addr, input int nbursts, input int ncu);
    int n, rem, c, nb;
    int ptr [N];
    logic [31:0] a;
    exp_data.delete(); exp_last.delete(); exp_addr.delete(); exp_nb.delete();
    for (int i = 0; i < N; i++) begin exp_pops[i] = 0; ptr[i] = 0; end
    n = (ncu == 0) ? 1 : ((ncu > N) ? N : ncu);
    rem = nbursts; a = addr; c = 0;
    while (rem > 0) begin
      nb = (rem < 8) ? rem : 8;
      exp_addr.push_back(a);
      exp_nb.push_back(32'(nb));
      for (int k = 0; k < nb * 16; k++) begin
        exp_data.push_back(bufm[c][ptr[c]]);
        ptr[c]++;
        exp_last.push_back((k % 16) == 15);
      end
      exp_pops[c] += nb * 16;
      a = a + 32'(nb * 128);
      rem -= nb;
      c = (c + 1) % n;
    end
  endtask

  task automatic start_cfg(input logic [31:0] addr, input int nbursts, input int ncu,
                           input int trm, input int wdm);
    logic acc;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      bptr[i] = 0; pops[i] = 0;
      for (int j = 0; j < 512; j++) bufm[i][j] = {$urandom, $urandom};
    end
    got_q.delete(); got_last.delete(); ws_addr.delete(); ws_nb.delete();
    done_cnt = 0; oh_err = 0; rd_wo_ws = 0; stab_err = 0; zero_err = 0;
    first_ws = -1; first_rd = -1; first_v = -1; first_beat = -1; last_beat = -1;
    tready_mode = trm; wdone_mode = wdm;
    build_expect(addr, nbursts, ncu);
    cfg_i_valid = 1'b1;
    cfg_i_data  = {10'd0, 4'(ncu), 18'(nbursts), addr};
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); acc = cfg_i_ready;
      @(posedge clk); #1;
    end
    cfg_i_valid = 1'b0;
    chk("cfg_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_results(input string tag);
    int mism, lastm, m;
    chk({tag, "_ws_count"}, 64'(ws_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < ws_addr.size()) begin
        chk($sformatf("%s_waddr%0d", tag, i), 64'(ws_addr[i]), 64'(exp_addr[i]));
        chk($sformatf("%s_wnburst%0d", tag, i), 64'(ws_nb[i]), 64'(exp_nb[i]));
      end
    end
    chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_data.size()));
    m = (got_q.size() < exp_data.size()) ? got_q.size() : exp_data.size();
    mism = 0; lastm = 0;
    for (int i = 0; i < m; i++) begin
      if (got_q[i] !== exp_data[i]) mism++;
      if (got_last[i] !== exp_last[i]) lastm++;
    end
    chk({tag, "_data_mismatches"}, 64'(mism), 64'd0);
    chk({tag, "_tlast_mismatches"}, 64'(lastm), 64'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_pops_cu%0d", tag, i), 64'(pops[i]), 64'(exp_pops[i]));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_rd_en_onehot_err"}, 64'(oh_err), 64'd0);
    chk({tag, "_rd_without_wstart"}, 64'(rd_wo_ws), 64'd0);
    chk({tag, "_stall_stability_err"}, 64'(stab_err), 64'd0);
    chk({tag, "_wregs_nonzero_idle"}, 64'(zero_err), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_ready_end"}, 64'(cfg_i_ready), 64'd1);
    chk({tag, "_tvalid_end"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_first_rd_lat"}, 64'(first_rd - first_ws), 64'd1);
    chk({tag, "_first_tvalid_lat"}, 64'(first_v - first_ws), 64'd2);
    chk({tag, "_no_bubbles"}, 64'(last_beat - first_beat), 64'd63);
  endtask

  initial begin
    // Reset behaviour
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 64'(cfg_i_ready), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_wstart", 64'(WSTART_REG), 64'd0);
    chk("rst_rd_en", 64'(ob_rd_en), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rel_cfg_ready", 64'(cfg_i_ready), 64'd1);

    // Single chunk, full throughput
    start_cfg(32'h1000_0000, 4, 1, 0, 0);
    wait_done();
    check_results("t1");
    check_timing("t1");

    // Round-robin over two units with a partial last chunk
    start_cfg(32'h1000_0000, 20, 2, 0, 0);
    wait_done();
    check_results("t2");

    // Random back-pressure
    start_cfg(32'h2000_0000, 8, 1, 1, 0);
    wait_done();
    check_results("t3");

    // Unit 1 not ready: controller must hold in selection
    ob_suff = 4'b1101;
    start_cfg(32'h3000_0000, 16, 2, 0, 0);
    for (int k = 0; k < 3000 && !(ws_addr.size() >= 1 && !WSTART_REG); k++) begin
      @(posedge clk); #1;
    end
    repeat (100) begin @(posedge clk); #1; end
    chk("t4_hold_ws_count", 64'(ws_addr.size()), 64'd1);
    chk("t4_hold_busy", 64'(busy_o), 64'd1);
    chk("t4_hold_wstart", 64'(WSTART_REG), 64'd0);
    chk("t4_hold_pops_cu1", 64'(pops[1]), 64'd0);
    ob_suff = 4'b1111;
    wait_done();
    check_results("t4");

    // Zero bursts
    start_cfg(32'h4000_0000, 0, 1, 0, 0);
    wait_done();
    check_results("t5");

    // Address wrap, three units, early WDONE, random back-pressure
    start_cfg(32'hFFFF_FF00, 20, 3, 1, 1);
    wait_done();
    check_results("t6");

    // Unit count 0 behaves as 1
    start_cfg(32'h5000_0000, 10, 0, 1, 0);
    wait_done();
    check_results("t7");

    // Reset in the middle of a transfer
    start_cfg(32'h6000_0000, 8, 1, 0, 0);
    for (int k = 0; k < 500 && got_q.size() < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("t8_reached_xfer", 64'(got_q.size() >= 10), 64'd1);
    rstn = 1'b0;
    #1;
    chk("t8_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t8_rst_wstart", 64'(WSTART_REG), 64'd0);
    chk("t8_rst_waddr", 64'(WADDR_REG), 64'd0);
    chk("t8_rst_wnburst", 64'(WNBURST_REG), 64'd0);
    chk("t8_rst_rd_en", 64'(ob_rd_en), 64'd0);
    chk("t8_rst_busy", 64'(busy_o), 64'd0);
    chk("t8_rst_cfg_ready", 64'(cfg_i_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #2;
    chk("t8_rel_cfg_ready", 64'(cfg_i_ready), 64'd1);
    start_cfg(32'h1000_0000, 4, 1, 0, 0);
    wait_done();
    check_results("t8");
    check_timing("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
